// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b cache types and data cache controller states
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [8:0]   lc3b_cache_tag;
    typedef logic [2:0]   lc3b_cache_index;
    typedef logic [3:0]   lc3b_cache_offset;
    typedef logic [127:0] lc3b_pmem_line;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } lc3b_dcache_state;

endpackage

// File: rtl/dcache_control_if.sv
// rtl/dcache_control_if.sv - CPU, way and physical memory buses of the data cache controller
interface dcache_control_if;
    import lc3b_types::*;

    lc3b_word        mem_address;
    logic            mem_read;
    logic            mem_write;
    logic [1:0]      mem_wmask;
    lc3b_word        mem_wdata;
    lc3b_word        mem_rdata;
    logic            mem_resp;

    logic            way0_valid;
    logic            way1_valid;
    logic            way0_dirty;
    logic            way1_dirty;
    lc3b_cache_tag   way0_tag;
    lc3b_cache_tag   way1_tag;
    lc3b_pmem_line   way0_data;
    lc3b_pmem_line   way1_data;
    lc3b_cache_index way_index;
    lc3b_cache_tag   way_tag;
    lc3b_pmem_line   way_data;
    logic            way0_load;
    logic            way1_load;
    logic            way_write_type;

    lc3b_word        pmem_address;
    logic            pmem_read;
    logic            pmem_write;
    lc3b_pmem_line   pmem_wdata;
    lc3b_pmem_line   pmem_rdata;
    logic            pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp,
        input  way0_valid, way1_valid, way0_dirty, way1_dirty,
        input  way0_tag, way1_tag, way0_data, way1_data,
        output way_index, way_tag, way_data, way0_load, way1_load, way_write_type,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp,
        output way0_valid, way1_valid, way0_dirty, way1_dirty,
        output way0_tag, way1_tag, way0_data, way1_data,
        input  way_index, way_tag, way_data, way0_load, way1_load, way_write_type,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/dcache_line_merge.sv
// rtl/dcache_line_merge.sv - inserts a CPU word's enabled bytes into a 128-bit cache line
module dcache_line_merge
    import lc3b_types::*;
(
    input  lc3b_pmem_line    line_in,
    input  lc3b_cache_offset offset,
    input  logic [1:0]       wmask,
    input  lc3b_word         wdata,
    output lc3b_pmem_line    line_out
);

    // Word-addressed writes: the byte bit of the offset does not pick a lane.
    logic unused_byte_sel;
    assign unused_byte_sel = offset[0];

    always_comb begin
        line_out = line_in;
        if (wmask[0]) line_out[{offset[3:1], 4'h0} +: 8] = wdata[7:0];
        if (wmask[1]) line_out[{offset[3:1], 4'h8} +: 8] = wdata[15:8];
    end

endmodule

// File: rtl/dcache_control.sv
// rtl/dcache_control.sv - 2-way data cache controller; DCACHE_PERF_CNT_EN adds hit/miss counters
module dcache_control
    import lc3b_types::*;
#(
    parameter int PERF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dcache_control_if.slave       bus,
    output logic [PERF_CNT_W-1:0] hit_count,
    output logic [PERF_CNT_W-1:0] miss_count
);

    lc3b_dcache_state state;
    logic [7:0]       lru;

    lc3b_cache_tag    req_tag;
    lc3b_cache_index  idx;
    lc3b_cache_offset off;
    logic             cpu_req, hit0, hit1, hit, hit_way, victim;
    logic             victim_valid, victim_dirty;
    lc3b_cache_tag    victim_tag;
    lc3b_pmem_line    victim_data, hit_line, merged_line;

    assign req_tag = bus.mem_address[15:7];
    assign idx     = bus.mem_address[6:4];
    assign off     = bus.mem_address[3:0];
    assign cpu_req = bus.mem_read | bus.mem_write;

    // Way 0 wins if both ways ever report the same tag.
    assign hit0    = bus.way0_valid & (bus.way0_tag == req_tag);
    assign hit1    = ~hit0 & bus.way1_valid & (bus.way1_tag == req_tag);
    assign hit     = hit0 | hit1;
    assign hit_way = hit1;
    assign victim  = lru[idx];

    assign hit_line     = hit_way ? bus.way1_data  : bus.way0_data;
    assign victim_valid = victim  ? bus.way1_valid : bus.way0_valid;
    assign victim_dirty = victim  ? bus.way1_dirty : bus.way0_dirty;
    assign victim_tag   = victim  ? bus.way1_tag   : bus.way0_tag;
    assign victim_data  = victim  ? bus.way1_data  : bus.way0_data;

    dcache_line_merge u_merge (
        .line_in  (hit_line),
        .offset   (off),
        .wmask    (bus.mem_wmask),
        .wdata    (bus.mem_wdata),
        .line_out (merged_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lru   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        if (hit)
                            lru[idx] <= ~hit_way;
                        else if (victim_valid && victim_dirty)
                            state <= WRITEBACK;
                        else
                            state <= ALLOCATE;
                    end
                end
                WRITEBACK: if (bus.pmem_resp) state <= ALLOCATE;
                ALLOCATE:  if (bus.pmem_resp) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    assign bus.way_index  = idx;
    assign bus.way_tag    = req_tag;
    assign bus.mem_rdata  = hit_line[{off[3:1], 4'h0} +: 16];
    assign bus.pmem_wdata = victim_data;

    always_comb begin
        bus.mem_resp       = 1'b0;
        bus.way0_load      = 1'b0;
        bus.way1_load      = 1'b0;
        bus.way_write_type = 1'b0;
        bus.way_data       = merged_line;
        bus.pmem_read      = 1'b0;
        bus.pmem_write     = 1'b0;
        bus.pmem_address   = {bus.mem_address[15:4], 4'h0};
        case (state)
            IDLE: begin
                if (cpu_req && hit) begin
                    bus.mem_resp = 1'b1;
                    if (bus.mem_write) begin
                        bus.way0_load      = ~hit_way;
                        bus.way1_load      = hit_way;
                        bus.way_write_type = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {victim_tag, idx, 4'h0};
            end
            ALLOCATE: begin
                bus.pmem_read = 1'b1;
                bus.way_data  = bus.pmem_rdata;
                if (bus.pmem_resp) begin
                    bus.way0_load = ~victim;
                    bus.way1_load = victim;
                end
            end
            default: ;
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] hit_cnt, miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (bus.mem_resp && hit_cnt != '1)
                hit_cnt <= hit_cnt + 1'b1;
            if (state == IDLE && cpu_req && !hit && miss_cnt != '1)
                miss_cnt <= miss_cnt + 1'b1;
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_control.sv
// tb/tb_dcache_control.sv - scoreboard bench for dcache_control against a flat-memory cache model
module tb_dcache_control;
    import lc3b_types::*;

    typedef struct {
        bit            is_write;
        logic [15:0]   addr;
        logic [127:0]  data;
    } pmem_exp_t;

    typedef struct {
        bit            is_write;
        logic [15:0]   rdata;
    } resp_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_control_if bus();
    logic [15:0] hit_count, miss_count;

    dcache_control #(.PERF_CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Two way arrays standing in for the dcache_set instances.
    bit           w_valid[2][8];
    bit           w_dirty[2][8];
    logic [8:0]   w_tag[2][8];
    logic [127:0] w_data[2][8];

    always_comb begin
        bus.way0_valid = w_valid[0][bus.way_index];
        bus.way1_valid = w_valid[1][bus.way_index];
        bus.way0_dirty = w_dirty[0][bus.way_index];
        bus.way1_dirty = w_dirty[1][bus.way_index];
        bus.way0_tag   = w_tag[0][bus.way_index];
        bus.way1_tag   = w_tag[1][bus.way_index];
        bus.way0_data  = w_data[0][bus.way_index];
        bus.way1_data  = w_data[1][bus.way_index];
    end

    always @(posedge clk) begin
        if (bus.way0_load) begin
            w_valid[0][bus.way_index] <= 1'b1;
            w_dirty[0][bus.way_index] <= bus.way_write_type;
            w_tag[0][bus.way_index]   <= bus.way_tag;
            w_data[0][bus.way_index]  <= bus.way_data;
        end
        if (bus.way1_load) begin
            w_valid[1][bus.way_index] <= 1'b1;
            w_dirty[1][bus.way_index] <= bus.way_write_type;
            w_tag[1][bus.way_index]   <= bus.way_tag;
            w_data[1][bus.way_index]  <= bus.way_data;
        end
    end

    // phys: backing store as the controller sees it; gmem: what the CPU should read.
    logic [127:0] phys[bit [11:0]];
    logic [127:0] gmem[bit [11:0]];

    function automatic logic [127:0] init_line(input bit [11:0] la);
        logic [127:0] l;
        for (int i = 0; i < 8; i++)
            l[i*16 +: 16] = 16'((int'(la) * 37 + i * 1013) ^ 16'hC3A5);
        return l;
    endfunction

    function automatic logic [127:0] phys_get(input bit [11:0] la);
        if (!phys.exists(la)) phys[la] = init_line(la);
        return phys[la];
    endfunction

    function automatic logic [127:0] gmem_get(input bit [11:0] la);
        if (!gmem.exists(la)) gmem[la] = init_line(la);
        return gmem[la];
    endfunction

    // Reference cache: which lines live where, which are dirty, and who is LRU.
    bit         m_valid[2][8], m_dirty[2][8];
    logic [8:0] m_tag[2][8];
    bit         m_lru[8];
    int         exp_hits = 0;
    int         exp_misses = 0;

    pmem_exp_t exp_pmem_q[$];
    resp_exp_t exp_resp_q[$];

    task automatic predict(input logic [15:0] a, input bit we, input logic [1:0] wm, input logic [15:0] wd);
        int idx, w, wi;
        logic [8:0] tag;
        logic [11:0] la;
        logic [127:0] line;
        pmem_exp_t pe;
        resp_exp_t re;
        idx = int'(a[6:4]);
        tag = a[15:7];
        w = -1;
        if (m_valid[0][idx] && m_tag[0][idx] == tag) w = 0;
        else if (m_valid[1][idx] && m_tag[1][idx] == tag) w = 1;
        if (w < 0) begin
            w = int'(m_lru[idx]);
            exp_misses++;
            if (m_valid[w][idx] && m_dirty[w][idx]) begin
                la = {m_tag[w][idx], a[6:4]};
                pe.is_write = 1'b1;
                pe.addr = {la, 4'h0};
                pe.data = gmem_get(la);
                exp_pmem_q.push_back(pe);
            end
            pe.is_write = 1'b0;
            pe.addr = {a[15:4], 4'h0};
            pe.data = '0;
            exp_pmem_q.push_back(pe);
            m_valid[w][idx] = 1'b1;
            m_tag[w][idx] = tag;
            m_dirty[w][idx] = 1'b0;
        end
        exp_hits++;
        m_lru[idx] = (w == 0);
        wi = int'(a[3:1]);
        line = gmem_get(a[15:4]);
        if (we) begin
            m_dirty[w][idx] = 1'b1;
            if (wm[0]) line[wi*16 +: 8] = wd[7:0];
            if (wm[1]) line[wi*16+8 +: 8] = wd[15:8];
            gmem[a[15:4]] = line;
        end
        re.is_write = we;
        re.rdata = line[wi*16 +: 16];
        exp_resp_q.push_back(re);
    endtask

    task automatic drive_req(input logic [15:0] a, input bit we, input logic [1:0] wm,
                             input logic [15:0] wd, output logic [15:0] rd);
        bit got;
        got = 1'b0;
        rd = 'x;
        bus.mem_address = a;
        bus.mem_read = ~we;
        bus.mem_write = we;
        bus.mem_wmask = wm;
        bus.mem_wdata = wd;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (bus.mem_resp) begin
                got = 1'b1;
                rd = bus.mem_rdata;
            end
        end
        if (!got) check("resp_timeout", 128'(got), 128'(1));
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic access(input logic [15:0] a, input bit we, input logic [1:0] wm,
                          input logic [15:0] wd, output logic [15:0] rd);
        predict(a, we, wm, wd);
        drive_req(a, we, wm, wd, rd);
    endtask

    // Response monitor plus bus invariants.
    always @(negedge clk) begin
        resp_exp_t e;
        if (rst_n) begin
            if (bus.mem_resp) begin
                if (exp_resp_q.size() == 0) begin
                    check("resp_unexpected", 128'(bus.mem_resp), 128'(0));
                end else begin
                    e = exp_resp_q.pop_front();
                    if (!e.is_write) check("mem_rdata", 128'(bus.mem_rdata), 128'(e.rdata));
                end
            end
            if (bus.pmem_read || bus.pmem_write)
                check("pmem_rd_wr_exclusive", 128'(bus.pmem_read & bus.pmem_write), 128'(0));
            if (bus.way0_load || bus.way1_load)
                check("way_load_exclusive", 128'(bus.way0_load & bus.way1_load), 128'(0));
        end
    end

    // Physical memory responder with random latency; drops a request cut by reset.
    initial begin
        bit is_w, abort;
        logic [15:0] pa;
        logic [127:0] wd;
        int lat;
        pmem_exp_t e;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n && (bus.pmem_read || bus.pmem_write)) begin
                is_w = bus.pmem_write;
                pa = bus.pmem_address;
                wd = bus.pmem_wdata;
                if (exp_pmem_q.size() == 0) begin
                    check("pmem_unexpected", 128'(pa), 128'hFFFF_FFFF);
                end else begin
                    e = exp_pmem_q.pop_front();
                    check("pmem_op", 128'(is_w), 128'(e.is_write));
                    check("pmem_address", 128'(pa), 128'(e.addr));
                    if (is_w) check("pmem_wdata", wd, e.data);
                end
                lat = $urandom_range(0, 3);
                abort = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(negedge clk);
                    if (!rst_n) abort = 1'b1;
                end
                if (!abort && rst_n) begin
                    if (!is_w) bus.pmem_rdata = phys_get(pa[15:4]);
                    bus.pmem_resp = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.pmem_resp = 1'b0;
                    if (is_w) phys[pa[15:4]] = wd;
                end
            end
        end
    end

    initial begin
        logic [15:0] rd;
        logic [127:0] l;
        bit sv_valid[2][8], sv_dirty[2][8];
        logic [8:0] sv_tag[2][8];
        bit seen;
        logic [15:0] a;

        bus.mem_address = '0;
        bus.mem_read = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_wmask = '0;
        bus.mem_wdata = '0;

        #2;
        check("rst_mem_resp", 128'(bus.mem_resp), 128'(0));
        check("rst_pmem_rw", 128'({bus.pmem_read, bus.pmem_write}), 128'(0));
        check("rst_way_load", 128'({bus.way0_load, bus.way1_load}), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold read fill with a known word.
        l = init_line(12'h123);
        l[47:32] = 16'hBEEF;
        phys[12'h123] = l;
        gmem[12'h123] = l;
        access(16'h1234, 1'b0, 2'b00, 16'h0, rd);
        check("cold_read_beef", 128'(rd), 128'(16'hBEEF));

        // Low-byte write hit, then read back the merged word.
        access(16'h1234, 1'b1, 2'b01, 16'hA55A, rd);
        access(16'h1234, 1'b0, 2'b00, 16'h0, rd);
        check("write_merge_be5a", 128'(rd), 128'(16'hBE5A));

        // Clean eviction of way1, then dirty writeback of way0.
        access(16'h5230, 1'b0, 2'b00, 16'h0, rd);
        access(16'h1230, 1'b0, 2'b00, 16'h0, rd);
        access(16'h9230, 1'b0, 2'b00, 16'h0, rd);
        access(16'hD230, 1'b0, 2'b00, 16'h0, rd);

        // Reset during ALLOCATE: request dropped and LRU cleared.
        sv_valid = m_valid;
        sv_dirty = m_dirty;
        sv_tag = m_tag;
        predict(16'h5230, 1'b0, 2'b00, 16'h0);
        bus.mem_address = 16'h5230;
        bus.mem_read = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.pmem_read) seen = 1'b1;
        end
        check("alloc_reached", 128'(seen), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_drops_pmem_read", 128'(bus.pmem_read), 128'(0));
        check("rst_drops_resp", 128'(bus.mem_resp), 128'(0));
        bus.mem_read = 1'b0;
        repeat (2) @(posedge clk);
        m_valid = sv_valid;
        m_dirty = sv_dirty;
        m_tag = sv_tag;
        for (int i = 0; i < 8; i++) m_lru[i] = 1'b0;
        exp_resp_q.delete();
        exp_pmem_q.delete();
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(16'h5230, 1'b0, 2'b00, 16'h0, rd);
        access(16'h9230, 1'b0, 2'b00, 16'h0, rd);

        // Random traffic over a few conflicting tags and sets.
        for (int n = 0; n < 400; n++) begin
            a = {7'($urandom_range(0, 3) * 5 + 1), 2'b00, 3'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            access(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), rd);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        check("resp_queue_drained", 128'(exp_resp_q.size()), 128'(0));
        check("pmem_queue_drained", 128'(exp_pmem_q.size()), 128'(0));
`ifdef DCACHE_PERF_CNT_EN
        check("hit_count", 128'(hit_count), 128'(exp_hits));
        check("miss_count", 128'(miss_count), 128'(exp_misses));
`else
        check("hit_count_tied", 128'(hit_count), 128'(0));
        check("miss_count_tied", 128'(miss_count), 128'(0));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_control.md
Name: dcache_control

Overview:
- Controller for the 2-way set-associative data cache built from two dcache_set instances (way 0, way 1).
- Performs hit detection, per-set LRU tracking, word/byte write merge, dirty-victim writeback and line allocation.
- Sits between the CPU memory port and physical memory (128-bit lines).
- Owns all way control signals: index, tag, line data, set_load, write_type.

Parameters:
- PERF_CNT_W, 16, width of the optional hit/miss counters.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- mem_address  in  16  CPU byte address; tag [15:7], index [6:4], offset [3:0]
- mem_read  in  1  CPU read request
- mem_write  in  1  CPU write request
- mem_wmask  in  2  byte enables for mem_wdata
- mem_wdata  in  16  CPU write word
- mem_rdata  out  16  CPU read word
- mem_resp  out  1  request complete this cycle
- way0_valid, way1_valid  in  1  valid bit from each way at index
- way0_dirty, way1_dirty  in  1  dirty bit from each way
- way0_tag, way1_tag  in  9  stored tag from each way
- way0_data, way1_data  in  128  stored line from each way
- way_index  out  3  index driven to both ways
- way_tag  out  9  tag to write
- way_data  out  128  line to write
- way0_load, way1_load  out  1  set_load for each way
- way_write_type  out  1  0 = fill from memory (dirty cleared), 1 = CPU modify (dirty set)
- pmem_address  out  16  line-aligned physical address
- pmem_read  out  1  line read request
- pmem_write  out  1  line write request
- pmem_wdata  out  128  victim line
- pmem_rdata  in  128  fetched line
- pmem_resp  in  1  physical memory done
- hit_count, miss_count  out  PERF_CNT_W  performance counters

Behaviour:
- Reset:
  - state = IDLE, all 8 LRU bits = 0.
  - All outputs are combinational from state; at reset every load/read/write/resp output is 0.
  - Reset mid-miss aborts the pmem transaction; physical memory must tolerate the dropped request.
- Hit detection: hitN = wayN_valid & (wayN_tag == mem_address[15:7]). Both ways hitting is illegal; way 0 takes priority.
- way_index = mem_address[6:4] in every state.
- LRU: lru[idx] names the least-recently-used way. A hit on way N sets lru[idx] = ~N. The victim is way lru[idx].
- IDLE:
  - Read hit: mem_resp = 1 in the same cycle. mem_rdata = word at offset[3:1] of the hit line. Update LRU. Stay in IDLE.
  - Write hit: mem_resp = 1 in the same cycle. Assert the hit way's load with way_write_type = 1 and way_tag = request tag. way_data = hit line with the selected word's bytes replaced per mem_wmask (bit0 → [7:0], bit1 → [15:8]). Update LRU.
  - Miss: if victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE. mem_resp = 0.
  - Read and write asserted together is illegal.
- WRITEBACK:
  - pmem_write = 1, pmem_address = {victim tag, idx, 4'b0}, pmem_wdata = victim line.
  - Hold until pmem_resp, then go to ALLOCATE.
- ALLOCATE:
  - pmem_read = 1, pmem_address = {mem_address[15:4], 4'b0}.
  - On pmem_resp: victim load = 1, way_write_type = 0, way_tag = request tag, way_data = pmem_rdata. Go to IDLE.
  - The retry in IDLE then hits, giving miss latency = writeback + fill + 1 cycle.
- The CPU holds its request stable until mem_resp. If the request drops mid-miss, the fill still completes and nothing is returned.
- pmem_read and pmem_write are never asserted together.

Optional Feature:
- DCACHE_PERF_CNT_EN defined:
  - hit_count increments on each IDLE cycle that produces mem_resp.
  - miss_count increments on each IDLE to WRITEBACK/ALLOCATE transition.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- lc3b_types gains lc3b_dcache_state (IDLE, WRITEBACK, ALLOCATE).
- lc3b_types already holds lc3b_cache_tag, lc3b_cache_index and lc3b_pmem_line; add lc3b_cache_offset.
- One sub-module: dcache_line_merge, a combinational word/byte insert into a 128-bit line from offset and wmask.

Test Plan:
- Cold read 0x1234: ALLOCATE with pmem_address 0x1230. Fill line word[2] = 0xBEEF. Next cycle mem_resp = 1, mem_rdata = 0xBEEF, way0 loaded with write_type 0.
- Write hit 0x1234, wdata 0xA55A, wmask 01: way0_load with write_type 1, word[2] = 0xBE5A, same-cycle mem_resp, lru[3] = 1.
- Fill 0x1230 (way0) and 0x5230 (way1), touch 0x1230, then read 0x9230: way1 evicted, no writeback because way1 is clean.
- Dirty 0x1230, then touch 0x5230 so way0 is LRU, then read 0x9230: WRITEBACK to 0x1230 carrying the dirty line, then ALLOCATE 0x9230.
- Assert rst_n = 0 during ALLOCATE: pmem_read drops immediately, state = IDLE, LRU bits all 0.
- With DCACHE_PERF_CNT_EN defined, run 3 hits and 2 misses: hit_count = 5 (each miss retry also counts as a hit), miss_count = 2.
